// File: rtl/pipe_hazard_ctrl_if.sv
// Hazard-controller bundle: ID/EX/MEM hazard inputs, async irq, and the stall/flush outputs.
interface pipe_hazard_ctrl_if #(
  parameter int unsigned REG_AW = 5
);
  logic [REG_AW-1:0] id_rs;
  logic [REG_AW-1:0] id_rt;
  logic              id_use_rs;
  logic              id_use_rt;
  logic              id_branch;
  logic              id_br_taken;
  logic              id_jump;
  logic              ex_memrd;
  logic              ex_regwrite;
  logic [REG_AW-1:0] ex_dst;
  logic              mem_memrd;
  logic [REG_AW-1:0] mem_dst;
  logic              irq;
  logic              pc_hold;
  logic              if_id_hold;
  logic              if_id_flush;
  logic              id_ex_flush;
  logic              irq_take;
  logic              irq_pend;

  modport master (
    output id_rs, id_rt, id_use_rs, id_use_rt, id_branch, id_br_taken, id_jump,
    output ex_memrd, ex_regwrite, ex_dst, mem_memrd, mem_dst, irq,
    input  pc_hold, if_id_hold, if_id_flush, id_ex_flush, irq_take, irq_pend
  );

  modport slave (
    input  id_rs, id_rt, id_use_rs, id_use_rt, id_branch, id_br_taken, id_jump,
    input  ex_memrd, ex_regwrite, ex_dst, mem_memrd, mem_dst, irq,
    output pc_hold, if_id_hold, if_id_flush, id_ex_flush, irq_take, irq_pend
  );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush controller for the 5-stage pipeline: load-use/branch bubbles, jump flush, IRQ take.
// Optional HAZ_PERF_CNT_EN adds stall_cycles/flush_cycles performance counters.
module pipe_hazard_ctrl #(
  parameter int unsigned REG_AW   = 5,
  parameter int unsigned LOAD_LAT = 1,
  parameter int unsigned IRQ_SYNC = 2
) (
  input  logic              clk,
  input  logic              reset,
  pipe_hazard_ctrl_if.slave hz
`ifdef HAZ_PERF_CNT_EN
  ,
  output logic [31:0]       stall_cycles,
  output logic [31:0]       flush_cycles
`endif
);

  localparam logic       StIdle      = 1'b0;
  localparam logic       StStall     = 1'b1;
  localparam bit         MultiBubble = (LOAD_LAT > 1);
  localparam logic [2:0] CntInit     = 3'(LOAD_LAT - 1);

  logic                state_q, state_d;
  logic [2:0]          cnt_q, cnt_d;
  logic [IRQ_SYNC-1:0] sync_q;
  logic                synced_q;
  logic                pend_q, pend_d;
  logic                lu_haz, br_haz, stall, jb_flush, take, rise;

  function automatic logic match(input logic [REG_AW-1:0] a, input logic [REG_AW-1:0] dst,
                                 input logic use_a);
    return (a == dst) && (dst != '0) && use_a;
  endfunction

  always_comb begin
    lu_haz = hz.ex_memrd && (match(hz.id_rs, hz.ex_dst, hz.id_use_rs) ||
                             match(hz.id_rt, hz.ex_dst, hz.id_use_rt));
    br_haz = hz.id_branch &&
             ((hz.ex_regwrite && (match(hz.id_rs, hz.ex_dst, hz.id_use_rs) ||
                                  match(hz.id_rt, hz.ex_dst, hz.id_use_rt))) ||
              (hz.mem_memrd && (match(hz.id_rs, hz.mem_dst, hz.id_use_rs) ||
                                match(hz.id_rt, hz.mem_dst, hz.id_use_rt))));
    stall    = (state_q == StStall) || lu_haz || br_haz;
    jb_flush = !stall && (hz.id_jump || (hz.id_branch && hz.id_br_taken));
    take     = pend_q && !stall && !jb_flush;
    rise     = sync_q[IRQ_SYNC-1] && !synced_q;
    // A new edge coinciding with the take cycle must survive the clear.
    pend_d   = rise || (pend_q && !take);
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      StIdle: begin
        if (lu_haz && MultiBubble) begin
          state_d = StStall;
          cnt_d   = CntInit;
        end
      end
      StStall: begin
        cnt_d = cnt_q - 3'd1;
        if (cnt_q == 3'd1) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= StIdle;
      cnt_q    <= '0;
      sync_q   <= '0;
      synced_q <= 1'b0;
      pend_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      sync_q   <= {sync_q[IRQ_SYNC-2:0], hz.irq};
      synced_q <= sync_q[IRQ_SYNC-1];
      pend_q   <= pend_d;
    end
  end

  // Outputs are forced low while reset is held so an abort takes effect immediately.
  assign hz.pc_hold     = !reset && stall;
  assign hz.if_id_hold  = !reset && stall;
  assign hz.if_id_flush = !reset && (jb_flush || take);
  assign hz.id_ex_flush = !reset && (stall || take);
  assign hz.irq_take    = !reset && take;
  assign hz.irq_pend    = !reset && pend_q;

`ifdef HAZ_PERF_CNT_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_cycles <= '0;
      flush_cycles <= '0;
    end else begin
      if (stall) stall_cycles <= stall_cycles + 32'd1;
      if (stall || jb_flush || take) flush_cycles <= flush_cycles + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl: one instance with LOAD_LAT=1, one with LOAD_LAT=3.
module tb_pipe_hazard_ctrl;
  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [4:0] id_rs, id_rt, ex_dst, mem_dst;
  logic       id_use_rs, id_use_rt, id_branch, id_br_taken, id_jump;
  logic       ex_memrd, ex_regwrite, mem_memrd, irq;
  int         checks = 0;
  int         failures = 0;

  always #5 clk = ~clk;

  pipe_hazard_ctrl_if #(.REG_AW(5)) hif1 ();
  pipe_hazard_ctrl_if #(.REG_AW(5)) hif3 ();

  assign hif1.id_rs = id_rs;             assign hif3.id_rs = id_rs;
  assign hif1.id_rt = id_rt;             assign hif3.id_rt = id_rt;
  assign hif1.id_use_rs = id_use_rs;     assign hif3.id_use_rs = id_use_rs;
  assign hif1.id_use_rt = id_use_rt;     assign hif3.id_use_rt = id_use_rt;
  assign hif1.id_branch = id_branch;     assign hif3.id_branch = id_branch;
  assign hif1.id_br_taken = id_br_taken; assign hif3.id_br_taken = id_br_taken;
  assign hif1.id_jump = id_jump;         assign hif3.id_jump = id_jump;
  assign hif1.ex_memrd = ex_memrd;       assign hif3.ex_memrd = ex_memrd;
  assign hif1.ex_regwrite = ex_regwrite; assign hif3.ex_regwrite = ex_regwrite;
  assign hif1.ex_dst = ex_dst;           assign hif3.ex_dst = ex_dst;
  assign hif1.mem_memrd = mem_memrd;     assign hif3.mem_memrd = mem_memrd;
  assign hif1.mem_dst = mem_dst;         assign hif3.mem_dst = mem_dst;
  assign hif1.irq = irq;                 assign hif3.irq = irq;

  // {pc_hold, if_id_hold, if_id_flush, id_ex_flush, irq_take, irq_pend}
  wire [5:0] o1 = {hif1.pc_hold, hif1.if_id_hold, hif1.if_id_flush, hif1.id_ex_flush,
                   hif1.irq_take, hif1.irq_pend};
  wire [5:0] o3 = {hif3.pc_hold, hif3.if_id_hold, hif3.if_id_flush, hif3.id_ex_flush,
                   hif3.irq_take, hif3.irq_pend};

`ifdef HAZ_PERF_CNT_EN
  logic [31:0] sc1, fc1, sc3, fc3;
  pipe_hazard_ctrl #(.REG_AW(5), .LOAD_LAT(1), .IRQ_SYNC(2)) dut1 (
    .clk(clk), .reset(reset), .hz(hif1), .stall_cycles(sc1), .flush_cycles(fc1));
  pipe_hazard_ctrl #(.REG_AW(5), .LOAD_LAT(3), .IRQ_SYNC(2)) dut3 (
    .clk(clk), .reset(reset), .hz(hif3), .stall_cycles(sc3), .flush_cycles(fc3));
`else
  pipe_hazard_ctrl #(.REG_AW(5), .LOAD_LAT(1), .IRQ_SYNC(2)) dut1 (
    .clk(clk), .reset(reset), .hz(hif1));
  pipe_hazard_ctrl #(.REG_AW(5), .LOAD_LAT(3), .IRQ_SYNC(2)) dut3 (
    .clk(clk), .reset(reset), .hz(hif3));
`endif

  localparam logic [5:0] Idle  = 6'b000000;
  localparam logic [5:0] Stall = 6'b110100;
  localparam logic [5:0] Jfl   = 6'b001000;

  task automatic clr_in();
    id_rs = 0; id_rt = 0; ex_dst = 0; mem_dst = 0;
    id_use_rs = 0; id_use_rt = 0; id_branch = 0; id_br_taken = 0; id_jump = 0;
    ex_memrd = 0; ex_regwrite = 0; mem_memrd = 0; irq = 0;
  endtask

  task automatic next();
    @(posedge clk); #1;
  endtask

  task automatic settle();
    #2;
  endtask

  task automatic do_reset();
    reset = 1'b1; clr_in();
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
  endtask

  task automatic set_lu();
    ex_memrd = 1; ex_dst = 8; id_rs = 8; id_use_rs = 1; id_rt = 3; id_use_rt = 1;
  endtask

  task automatic test_reset();
    reset = 1'b1; set_lu(); id_jump = 1; settle();
    checks++;
    if (o1 !== Idle) begin failures++; $display("FAIL reset_o1 got=%b exp=%b", o1, Idle); end
    checks++;
    if (o3 !== Idle) begin failures++; $display("FAIL reset_o3 got=%b exp=%b", o3, Idle); end
    do_reset();
  endtask

  task automatic test_load_use_1();
    do_reset(); next(); set_lu(); settle();
    checks++;
    if (o1 !== Stall) begin failures++; $display("FAIL lu1_c0 got=%b exp=%b", o1, Stall); end
    next(); ex_memrd = 0; mem_memrd = 1; mem_dst = 8; settle();
    checks++;
    if (o1 !== Idle) begin failures++; $display("FAIL lu1_c1 got=%b exp=%b", o1, Idle); end
  endtask

  task automatic test_load_use_3();
    logic [5:0] exp_v [4] = '{Stall, Stall, Stall, Idle};
    do_reset(); next(); set_lu();
    for (int c = 0; c < 4; c++) begin
      settle();
      checks++;
      if (o3 !== exp_v[c]) begin
        failures++; $display("FAIL lu3_c%0d got=%b exp=%b", c, o3, exp_v[c]);
      end
      next(); clr_in();
    end
    // Reset during the second bubble aborts the remaining ones.
    do_reset(); next(); set_lu(); settle(); next(); clr_in(); settle();
    checks++;
    if (o3 !== Stall) begin failures++; $display("FAIL lu3_abort_pre got=%b exp=%b", o3, Stall); end
    reset = 1'b1; #1;
    checks++;
    if (o3 !== Idle) begin failures++; $display("FAIL lu3_abort_rst got=%b exp=%b", o3, Idle); end
    @(posedge clk); #1 reset = 1'b0; settle();
    checks++;
    if (o3 !== Idle) begin failures++; $display("FAIL lu3_abort_post got=%b exp=%b", o3, Idle); end
  endtask

  task automatic test_jump();
    do_reset(); next();
    ex_memrd = 1; ex_dst = 0; id_rs = 0; id_use_rs = 1; settle();
    checks++;
    if (o3 !== Idle) begin failures++; $display("FAIL r0_nostall got=%b exp=%b", o3, Idle); end
    ex_dst = 8; id_rs = 8; id_use_rs = 0; id_rt = 8; id_use_rt = 0; settle();
    checks++;
    if (o3 !== Idle) begin failures++; $display("FAIL nouse_nostall got=%b exp=%b", o3, Idle); end
    ex_memrd = 0; id_jump = 1; settle();
    checks++;
    if (o3 !== Jfl) begin failures++; $display("FAIL jump_flush got=%b exp=%b", o3, Jfl); end
    next(); id_jump = 0; settle();
    checks++;
    if (o3 !== Idle) begin failures++; $display("FAIL jump_done got=%b exp=%b", o3, Idle); end
    set_lu(); id_jump = 1; settle();
    checks++;
    if (o1 !== Stall) begin failures++; $display("FAIL jump_vs_stall got=%b exp=%b", o1, Stall); end
    next(); ex_memrd = 0; settle();
    checks++;
    if (o1 !== Jfl) begin failures++; $display("FAIL jump_after_stall got=%b exp=%b", o1, Jfl); end
  endtask

  task automatic test_branch();
    do_reset(); next();
    id_branch = 1; id_br_taken = 1; id_rs = 4; id_rt = 9; id_use_rs = 1; id_use_rt = 1;
    ex_regwrite = 1; ex_dst = 9; settle();
    checks++;
    if (o1 !== Stall) begin failures++; $display("FAIL br_ex_stall got=%b exp=%b", o1, Stall); end
    next(); ex_regwrite = 0; settle();
    checks++;
    if (o1 !== Jfl) begin failures++; $display("FAIL br_taken_flush got=%b exp=%b", o1, Jfl); end
    next(); id_br_taken = 0; mem_memrd = 1; mem_dst = 4; settle();
    checks++;
    if (o1 !== Stall) begin failures++; $display("FAIL br_mem_stall got=%b exp=%b", o1, Stall); end
    next(); mem_memrd = 0; settle();
    checks++;
    if (o1 !== Idle) begin failures++; $display("FAIL br_not_taken got=%b exp=%b", o1, Idle); end
  endtask

  task automatic test_irq_stall();
    logic [5:0] exp_v [5] = '{Stall, 6'b110101, 6'b110101, 6'b001111, Idle};
    do_reset(); next(); irq = 1; settle();
    next(); settle();
    checks++;
    if (o3 !== Idle) begin failures++; $display("FAIL irq_pend_early got=%b exp=%b", o3, Idle); end
    next(); irq = 0; set_lu();
    for (int c = 0; c < 5; c++) begin
      settle();
      checks++;
      if (o3 !== exp_v[c]) begin
        failures++; $display("FAIL irq_stall_c%0d got=%b exp=%b", c, o3, exp_v[c]);
      end
      next(); clr_in();
    end
  endtask

  task automatic test_irq_merge();
    logic [5:0] exp_v [4] = '{6'b001001, 6'b001111, 6'b001111, Idle};
    do_reset(); next(); irq = 1; next(); irq = 0; next(); irq = 1; settle();
    checks++;
    if (o3 !== Idle) begin failures++; $display("FAIL merge_pre got=%b exp=%b", o3, Idle); end
    next(); id_jump = 1;
    for (int c = 0; c < 4; c++) begin
      settle();
      checks++;
      if (o3 !== exp_v[c]) begin
        failures++; $display("FAIL merge_c%0d got=%b exp=%b", c, o3, exp_v[c]);
      end
      next(); id_jump = 0; if (c == 1) irq = 0;
    end
  endtask

  task automatic test_back_to_back();
    logic [5:0] exp_v [7] = '{Stall, Stall, Stall, Stall, Stall, Stall, Idle};
    do_reset(); next();
    for (int c = 0; c < 7; c++) begin
      if (c == 0 || c == 3) set_lu();
      settle();
      checks++;
      if (o3 !== exp_v[c]) begin
        failures++; $display("FAIL b2b_c%0d got=%b exp=%b", c, o3, exp_v[c]);
      end
      next(); clr_in();
    end
  endtask

  task automatic test_irq_level();
    int takes = 0;
    do_reset(); next(); irq = 1;
    for (int c = 0; c < 14; c++) begin
      settle();
      if (hif3.irq_take === 1'b1) takes++;
      next();
      if (c == 9) irq = 0;
    end
    checks++;
    if (takes != 1) begin failures++; $display("FAIL irq_level_takes got=%0d exp=1", takes); end
    checks++;
    if (o3 !== Idle) begin failures++; $display("FAIL irq_level_end got=%b exp=%b", o3, Idle); end
`ifdef HAZ_PERF_CNT_EN
    set_lu(); next(); clr_in(); next(); next(); settle();
    checks++;
    if (sc3 !== 32'd3) begin failures++; $display("FAIL perf_stall got=%0d exp=3", sc3); end
    checks++;
    if (fc3 !== 32'd4) begin failures++; $display("FAIL perf_flush got=%0d exp=4", fc3); end
`endif
  endtask

  initial begin
    clr_in();
    test_reset();
    test_load_use_1();
    test_load_use_3();
    test_jump();
    test_branch();
    test_irq_stall();
    test_irq_merge();
    test_back_to_back();
    test_irq_level();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
